// File: rtl/lc3b_memory.sv
// LC-3b memory responder: fixed-latency word store with byte-lane writes behind MEMEN/R.
// Optional unaligned-word detection is enabled by defining MEM_ALIGN_CHECK_EN.
module lc3b_memory #(
    parameter int AW      = 10,
    parameter int LATENCY = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MEMEN,
    input  logic        RW,
    input  logic        SIZE,
    input  logic [15:0] MAR,
    input  logic [15:0] MDR_IN,
    output logic        R,
    output logic [15:0] MEM_OUT,
    output logic        ERR
);

    // state | meaning
    // IDLE  | waiting for MEMEN; request latched on acceptance
    // WAIT  | down-counting access latency; MEMEN low aborts
    // DONE  | R high for one cycle; writes commit on the edge leaving DONE
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [3:0]    count;
    logic [AW:0]   latMar;
    logic          latRw;
    logic          latSize;
    logic [15:0]   latData;

    logic [15:0]   mem [0:(2**AW)-1];

    // Address bits above the word index are intentionally dropped (wrap).
    logic          unusedMarHi;
    assign unusedMarHi = ^MAR[15:AW+1];

    // When LATENCY==1 the access enters DONE straight from IDLE, so the
    // completing request comes from the live inputs rather than the latch.
    logic          enterFromIdle;
    logic [AW-1:0] doneIdx;
    logic          doneRw;
    logic          doneSize;
    logic          doneOdd;
    logic          doneMisalign;

    assign enterFromIdle = (state == IDLE);
    assign doneIdx       = enterFromIdle ? MAR[AW:1] : latMar[AW:1];
    assign doneRw        = enterFromIdle ? RW        : latRw;
    assign doneSize      = enterFromIdle ? SIZE      : latSize;
    assign doneOdd       = enterFromIdle ? MAR[0]    : latMar[0];

`ifdef MEM_ALIGN_CHECK_EN
    assign doneMisalign = doneSize & doneOdd;
`else
    assign doneMisalign = 1'b0;
`endif

    logic          latMisalign;
    logic          commit;
    logic          loEn;
    logic          hiEn;

`ifdef MEM_ALIGN_CHECK_EN
    assign latMisalign = latSize & latMar[0];
`else
    assign latMisalign = 1'b0;
`endif

    assign commit = (state == DONE) && latRw;
    assign loEn   = commit && (latSize ? !latMisalign : !latMar[0]);
    assign hiEn   = commit && (latSize ? !latMisalign :  latMar[0]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            count   <= 4'd0;
            latMar  <= '0;
            latRw   <= 1'b0;
            latSize <= 1'b0;
            latData <= 16'h0000;
            R       <= 1'b0;
            MEM_OUT <= 16'h0000;
            ERR     <= 1'b0;
        end else begin
            R   <= 1'b0;
            ERR <= 1'b0;
            case (state)
                IDLE: begin
                    if (MEMEN) begin
                        latMar  <= MAR[AW:0];
                        latRw   <= RW;
                        latSize <= SIZE;
                        latData <= MDR_IN;
                        count   <= 4'(LATENCY - 1);
                        if (LATENCY == 1) begin
                            state <= DONE;
                            R     <= 1'b1;
                            ERR   <= doneMisalign;
                            if (!doneRw)
                                MEM_OUT <= mem[doneIdx];
                        end else begin
                            state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!MEMEN) begin
                        state <= IDLE;
                    end else if (count == 4'd1) begin
                        state <= DONE;
                        count <= 4'd0;
                        R     <= 1'b1;
                        ERR   <= doneMisalign;
                        if (!doneRw)
                            MEM_OUT <= mem[doneIdx];
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Storage is deliberately outside the reset domain: contents survive reset.
    always_ff @(posedge clk) begin
        if (loEn)
            mem[latMar[AW:1]][7:0] <= latData[7:0];
        if (hiEn)
            mem[latMar[AW:1]][15:8] <= latData[15:8];
    end

endmodule

// File: tb/tb_lc3b_memory.sv
// Directed self-checking bench for lc3b_memory (default AW=10, LATENCY=5).
// Expectations for unaligned word writes follow MEM_ALIGN_CHECK_EN when defined.
module tb_lc3b_memory;

    logic        clk = 1'b0;
    logic        reset;
    logic        MEMEN;
    logic        RW;
    logic        SIZE;
    logic [15:0] MAR;
    logic [15:0] MDR_IN;
    logic        R;
    logic [15:0] MEM_OUT;
    logic        ERR;

    int checks = 0;
    int errors = 0;

    lc3b_memory dut (
        .clk    (clk),
        .reset  (reset),
        .MEMEN  (MEMEN),
        .RW     (RW),
        .SIZE   (SIZE),
        .MAR    (MAR),
        .MDR_IN (MDR_IN),
        .R      (R),
        .MEM_OUT(MEM_OUT),
        .ERR    (ERR)
    );

    always #5 clk = ~clk;

    // One complete access; inputs are scrambled after acceptance to prove latching.
    task automatic access(input logic rw, input logic sz, input logic [15:0] mar,
                          input logic [15:0] dat, output logic [15:0] rdata,
                          output logic errv, output int lat, output logic rAfter);
        @(negedge clk);
        MEMEN = 1'b1; RW = rw; SIZE = sz; MAR = mar; MDR_IN = dat;
        lat = -1;
        rdata = 16'hxxxx;
        errv = 1'bx;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (R === 1'b1) begin
                lat = k;
                break;
            end
            if (k == 1) begin
                RW = ~rw; SIZE = ~sz; MAR = mar ^ 16'h5556; MDR_IN = ~dat;
            end
        end
        rdata = MEM_OUT;
        errv  = ERR;
        MEMEN = 1'b0;
        @(negedge clk);
        rAfter = R;
    endtask

    task automatic test_reset();
        int lat;
        reset = 1'b0; MEMEN = 1'b1; RW = 1'b0; SIZE = 1'b1; MAR = 16'h0000; MDR_IN = 16'h0000;
        repeat (3) @(negedge clk);
        checks++; if (R !== 1'b0) begin errors++; $display("FAIL reset_R got %b want 0", R); end
        checks++; if (MEM_OUT !== 16'h0000) begin errors++; $display("FAIL reset_MEM_OUT got %h want 0000", MEM_OUT); end
        checks++; if (ERR !== 1'b0) begin errors++; $display("FAIL reset_ERR got %b want 0", ERR); end
        reset = 1'b1;
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (R === 1'b1) begin lat = k; break; end
        end
        MEMEN = 1'b0;
        checks++; if (lat !== 5) begin errors++; $display("FAIL reset_release_latency got %0d want 5", lat); end
        @(negedge clk);
    endtask

    task automatic test_word_rw();
        logic [15:0] d; logic e; int lat; logic ra;
        access(1'b1, 1'b1, 16'h3000, 16'hBEEF, d, e, lat, ra);
        checks++; if (lat !== 5) begin errors++; $display("FAIL word_write_latency got %0d want 5", lat); end
        checks++; if (ra !== 1'b0) begin errors++; $display("FAIL word_write_R_width got %b want 0", ra); end
        access(1'b0, 1'b1, 16'h3000, 16'h0000, d, e, lat, ra);
        checks++; if (lat !== 5) begin errors++; $display("FAIL word_read_latency got %0d want 5", lat); end
        checks++; if (d !== 16'hBEEF) begin errors++; $display("FAIL word_read_data got %h want beef", d); end
        checks++; if (ra !== 1'b0) begin errors++; $display("FAIL word_read_R_width got %b want 0", ra); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL word_read_ERR got %b want 0", e); end
    endtask

    task automatic test_byte_write();
        logic [15:0] d; logic e; int lat; logic ra;
        access(1'b1, 1'b0, 16'h3001, 16'h1212, d, e, lat, ra);
        checks++; if (d !== 16'hBEEF) begin errors++; $display("FAIL write_keeps_MEM_OUT got %h want beef", d); end
        access(1'b0, 1'b0, 16'h3001, 16'h0000, d, e, lat, ra);
        checks++; if (d !== 16'h12EF) begin errors++; $display("FAIL byte_write_hi got %h want 12ef", d); end
        access(1'b1, 1'b0, 16'h3000, 16'h3434, d, e, lat, ra);
        access(1'b0, 1'b0, 16'h3000, 16'h0000, d, e, lat, ra);
        checks++; if (d !== 16'h1234) begin errors++; $display("FAIL byte_write_lo got %h want 1234", d); end
    endtask

    task automatic test_abort();
        logic [15:0] d; logic e; int lat; logic ra; int rCount;
        access(1'b1, 1'b1, 16'h3002, 16'h1111, d, e, lat, ra);
        @(negedge clk);
        MEMEN = 1'b1; RW = 1'b1; SIZE = 1'b1; MAR = 16'h3002; MDR_IN = 16'hAAAA;
        rCount = 0;
        repeat (3) begin
            @(negedge clk);
            if (R === 1'b1) rCount++;
        end
        MEMEN = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (R === 1'b1) rCount++;
        end
        checks++; if (rCount !== 0) begin errors++; $display("FAIL abort_no_R got %0d R pulses want 0", rCount); end
        access(1'b0, 1'b1, 16'h3002, 16'h0000, d, e, lat, ra);
        checks++; if (d !== 16'h1111) begin errors++; $display("FAIL abort_no_write got %h want 1111", d); end
    endtask

    task automatic test_wrap();
        logic [15:0] d; logic e; int lat; logic ra;
        access(1'b1, 1'b1, 16'h0802, 16'h5A5A, d, e, lat, ra);
        access(1'b0, 1'b1, 16'h0002, 16'h0000, d, e, lat, ra);
        checks++; if (d !== 16'h5A5A) begin errors++; $display("FAIL wrap_read got %h want 5a5a", d); end
    endtask

    task automatic test_reset_mid_access();
        logic [15:0] d; logic e; int lat; logic ra;
        access(1'b1, 1'b1, 16'h3004, 16'h7777, d, e, lat, ra);
        @(negedge clk);
        MEMEN = 1'b1; RW = 1'b1; SIZE = 1'b1; MAR = 16'h3004; MDR_IN = 16'h9999;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (R !== 1'b0) begin errors++; $display("FAIL midreset_R got %b want 0", R); end
        checks++; if (MEM_OUT !== 16'h0000) begin errors++; $display("FAIL midreset_MEM_OUT got %h want 0000", MEM_OUT); end
        MEMEN = 1'b0;
        reset = 1'b1;
        access(1'b0, 1'b1, 16'h3004, 16'h0000, d, e, lat, ra);
        checks++; if (d !== 16'h7777) begin errors++; $display("FAIL midreset_no_write got %h want 7777", d); end
    endtask

    task automatic test_back_to_back();
        int firstR; int gap;
        @(negedge clk);
        MEMEN = 1'b1; RW = 1'b0; SIZE = 1'b1; MAR = 16'h3000; MDR_IN = 16'h0000;
        firstR = -1; gap = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (R === 1'b1) begin
                if (firstR < 0) firstR = k;
                else begin gap = k - firstR; break; end
            end
        end
        MEMEN = 1'b0;
        checks++; if (firstR !== 5) begin errors++; $display("FAIL b2b_first_latency got %0d want 5", firstR); end
        checks++; if (gap !== 6) begin errors++; $display("FAIL b2b_gap got %0d want 6", gap); end
        checks++; if (MEM_OUT !== 16'h1234) begin errors++; $display("FAIL b2b_data got %h want 1234", MEM_OUT); end
        @(negedge clk);
    endtask

    task automatic test_unaligned();
        logic [15:0] d; logic e; int lat; logic ra;
        logic expErr; logic [15:0] expWord;
`ifdef MEM_ALIGN_CHECK_EN
        expErr = 1'b1; expWord = 16'h1111;
`else
        expErr = 1'b0; expWord = 16'hFFFF;
`endif
        access(1'b1, 1'b1, 16'h3003, 16'hFFFF, d, e, lat, ra);
        checks++; if (e !== expErr) begin errors++; $display("FAIL unaligned_ERR got %b want %b", e, expErr); end
        checks++; if (lat !== 5) begin errors++; $display("FAIL unaligned_latency got %0d want 5", lat); end
        access(1'b0, 1'b1, 16'h3002, 16'h0000, d, e, lat, ra);
        checks++; if (d !== expWord) begin errors++; $display("FAIL unaligned_word got %h want %h", d, expWord); end
        checks++; if (e !== 1'b0) begin errors++; $display("FAIL aligned_read_ERR got %b want 0", e); end
        access(1'b0, 1'b1, 16'h3003, 16'h0000, d, e, lat, ra);
        checks++; if (d !== expWord) begin errors++; $display("FAIL unaligned_read_data got %h want %h", d, expWord); end
        checks++; if (e !== expErr) begin errors++; $display("FAIL unaligned_read_ERR got %b want %b", e, expErr); end
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_byte_write();
        test_abort();
        test_wrap();
        test_reset_mid_access();
        test_back_to_back();
        test_unaligned();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
